div_clk_checker: RTL and testbench
==================================

# div_clk_checker

Lock and duty monitor for a divided clock produced by the counter-based clock divider on the same `clk_in`. It samples the divided clock in the `clk_in` domain and measures every high and low phase in `clk_in` cycles. It declares lock after a run of correct phases and raises a sticky error on loss of lock. It sits directly downstream of the divider and gives bring-up and BIST logic a pass/fail view of the divider output.

## Interface
- `DIVIDOR`, default 5: expected length of each phase (high and low) in `clk_in` cycles. Period is 2*DIVIDOR.
- `LOCK_COUNT`, default 4: number of consecutive correct phases required to lock.
- `CNT_W`, default 8: run-length counter width. Must satisfy 2^CNT_W - 1 >= 2*DIVIDOR.
- `PCNT_W`, default 16: width of the locked-period counter.
- `clk_in`, input, 1: system clock. The divided clock is generated from this clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `div_clk`, input, 1: divided clock under test. It is registered on `clk_in` upstream, so it is synchronous and needs no synchronizer.
- `clear`, input, 1: synchronous clear of all state, checker only.
- `locked`, output, 1: high while in LOCKED.
- `err`, output, 1: sticky loss-of-lock flag.
- `hi_len`, output, CNT_W: length of the last completed high phase.
- `lo_len`, output, CNT_W: length of the last completed low phase.
- `period_cnt`, output, PCNT_W: count of rising edges seen while LOCKED. Saturating.

## Operation
- **Edge detection**
  - `div_q` <= `div_clk` each cycle.
  - rise = `div_clk` & ~`div_q`; fall = ~`div_clk` & `div_q`; edge = rise | fall. All combinational.
- **Run counter `run`**
  - On edge: `run` <= 1.
  - Otherwise: `run` <= `run` + 1, saturating at all-ones.
  - At an edge, `run` equals the length of the phase that just ended.
- **Phase capture**
  - On fall: `hi_len` <= `run`.
  - On rise: `lo_len` <= `run`.
  - Capture happens only when `primed` = 1.
  - The first edge after reset or clear only sets `primed`, because that phase is partial. It does not capture or check.
- **Phase check**
  - A primed edge with `run` == DIVIDOR is a good phase.
  - A primed edge with any other `run` value is a bad phase.
- **Timeout**
  - Fires when state != UNLOCKED, there is no edge this cycle, and `run` == 2*DIVIDOR.
  - It marks the clock as stuck.
- **FSM: UNLOCKED (reset state)**
  - On edge: `primed` <= 1, `good_cnt` <= 0, go to ACQUIRE.
- **FSM: ACQUIRE**
  - Good phase: `good_cnt`++. When `good_cnt` reaches LOCKED_COUNT - 1 and this phase is good, go to LOCKED.
  - Bad phase: `good_cnt` <= 0, stay in ACQUIRE.
  - Timeout: go to UNLOCKED, `primed` <= 0. `err` is unchanged.
- **FSM: LOCKED**
  - Bad phase: `err` <= 1, `good_cnt` <= 0, go to ACQUIRE.
  - Timeout: `err` <= 1, `primed` <= 0, go to UNLOCKED.
  - Rise with a good phase: `period_cnt`++, saturating at 2^PCNT_W - 1.
- **Clear**
  - `clear` = 1 forces the state of reset on the next edge.
  - `clear` overrides every simultaneous edge, timeout or check in the same cycle.
- `err` is set only from LOCKED. A mismatch in ACQUIRE only restarts acquisition.

## Timing
- **Reset values:** `locked`=0, `err`=0, `hi_len`=0, `lo_len`=0, `period_cnt`=0, state UNLOCKED, `primed`=0, `run`=0, `div_q`=0.
- **Reset release with `div_clk`=1:** detected as a rise in the first cycle and handled as the priming edge.
- **Edge detection:** same cycle as the `div_clk` change.
- **Updates from an edge:** `hi_len`, `lo_len`, state and `err` update at the next `clk_in` edge.
- **Output latency:** `locked` and `err` are registered, with 1-cycle latency from the deciding edge.
- **Lock time:** with a clean input, `locked` rises 1 cycle after the LOCK_COUNT-th good phase. That is LOCK_COUNT*DIVIDOR + 1 cycles after the priming edge, plus the registered output.
- **Loss of lock:** `locked` falls in the same cycle `err` rises.
- **Timeout:** fires exactly once per stuck episode, then remains inactive in UNLOCKED until an edge arrives.
- **Async reset mid-operation:** all outputs go to their reset values immediately, independent of `clk_in`.

## Test plan
All scenarios use DIVIDOR=5, LOCK_COUNT=4, PCNT_W=4.

1. **Clean acquisition.** Stimulus: after reset, drive `div_clk` with 5 high / 5 low. Required: first edge primes; `locked`=1 one cycle after the 4th checked phase; `hi_len`=`lo_len`=5; `err`=0.
2. **Stretched phase while locked.** Stimulus: one high phase of 6 cycles. Required: `hi_len`=6, `err`=1, `locked`=0 one cycle after the fall. Then `locked`=1 again after 4 further good phases, with `err` still 1.
3. **Stuck clock while locked.** Stimulus: hold `div_clk` low for 20 cycles. Required: timeout when `run`==10, then `err`=1, `locked`=0, state UNLOCKED. On restart, the first edge primes only, and the clock relocks after 4 good phases.
4. **Clear on an edge.** Stimulus: assert `clear` in the same cycle as a mismatched edge while locked. Required: next cycle all outputs are 0 and `err` stays 0.
5. **Async reset in ACQUIRE.** Stimulus: pulse `rst` mid-phase, between `clk_in` edges. Required: all outputs 0 immediately. After release, acquisition restarts from the priming edge.
6. **Saturation.** Stimulus: stay locked for 20 periods. Required: `period_cnt` stops at 15 and does not wrap.

Source files
------------

// File: rtl/div_clk_checker.sv
// Lock and duty monitor for a counter-divided clock sampled in the clk_in domain.
// Measures every high/low phase, declares lock after a run of good phases, flags loss of lock.
module div_clk_checker #(
  parameter int unsigned DIVIDOR    = 5,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned PCNT_W     = 16
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              div_clk,
  input  logic              clear,
  output logic              locked,
  output logic              err,
  output logic [CNT_W-1:0]  hi_len,
  output logic [CNT_W-1:0]  lo_len,
  output logic [PCNT_W-1:0] period_cnt
);

  localparam int unsigned GoodW = $clog2(LOCK_COUNT) + 1;

  localparam logic [CNT_W-1:0]  PhaseLen   = CNT_W'(DIVIDOR);
  localparam logic [CNT_W-1:0]  TimeoutLen = CNT_W'(2 * DIVIDOR);
  localparam logic [CNT_W-1:0]  RunMax     = {CNT_W{1'b1}};
  localparam logic [PCNT_W-1:0] PcntMax    = {PCNT_W{1'b1}};
  localparam logic [GoodW-1:0]  LastGood   = GoodW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {StUnlocked, StAcquire, StLocked} state_e;

  state_e              state_q, state_d;
  logic                div_q_q, div_q_d;
  logic                primed_q, primed_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    run_q, run_d;
  logic [CNT_W-1:0]    hi_len_q, hi_len_d;
  logic [CNT_W-1:0]    lo_len_q, lo_len_d;
  logic [PCNT_W-1:0]   period_cnt_q, period_cnt_d;
  logic [GoodW-1:0]    good_cnt_q, good_cnt_d;

  logic rise, fall, edge_seen, good_phase, bad_phase, timeout;

  always_comb begin
    rise       = div_clk & ~div_q_q;
    fall       = ~div_clk & div_q_q;
    edge_seen  = rise | fall;
    // The first edge after reset/clear closes a partial phase, so it is never judged.
    good_phase = primed_q & edge_seen & (run_q == PhaseLen);
    bad_phase  = primed_q & edge_seen & (run_q != PhaseLen);
    timeout    = (state_q != StUnlocked) & ~edge_seen & (run_q == TimeoutLen);
  end

  always_comb begin
    state_d      = state_q;
    div_q_d      = div_clk;
    primed_d     = primed_q;
    err_d        = err_q;
    hi_len_d     = hi_len_q;
    lo_len_d     = lo_len_q;
    period_cnt_d = period_cnt_q;
    good_cnt_d   = good_cnt_q;

    if (edge_seen) begin
      run_d = CNT_W'(1);
    end else if (run_q == RunMax) begin
      run_d = run_q;
    end else begin
      run_d = run_q + CNT_W'(1);
    end

    if (primed_q && fall) hi_len_d = run_q;
    if (primed_q && rise) lo_len_d = run_q;

    case (state_q)
      StUnlocked: begin
        if (edge_seen) begin
          primed_d   = 1'b1;
          good_cnt_d = '0;
          state_d    = StAcquire;
        end
      end
      StAcquire: begin
        if (good_phase) begin
          good_cnt_d = good_cnt_q + GoodW'(1);
          if (good_cnt_q == LastGood) state_d = StLocked;
        end else if (bad_phase) begin
          good_cnt_d = '0;
        end else if (timeout) begin
          primed_d = 1'b0;
          state_d  = StUnlocked;
        end
      end
      StLocked: begin
        if (bad_phase) begin
          err_d      = 1'b1;
          good_cnt_d = '0;
          state_d    = StAcquire;
        end else if (timeout) begin
          err_d    = 1'b1;
          primed_d = 1'b0;
          state_d  = StUnlocked;
        end else if (good_phase && rise && (period_cnt_q != PcntMax)) begin
          period_cnt_d = period_cnt_q + PCNT_W'(1);
        end
      end
      default: state_d = StUnlocked;
    endcase

    if (clear) begin
      state_d      = StUnlocked;
      div_q_d      = 1'b0;
      primed_d     = 1'b0;
      err_d        = 1'b0;
      run_d        = '0;
      hi_len_d     = '0;
      lo_len_d     = '0;
      period_cnt_d = '0;
      good_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q      <= StUnlocked;
      div_q_q      <= 1'b0;
      primed_q     <= 1'b0;
      err_q        <= 1'b0;
      run_q        <= '0;
      hi_len_q     <= '0;
      lo_len_q     <= '0;
      period_cnt_q <= '0;
      good_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      div_q_q      <= div_q_d;
      primed_q     <= primed_d;
      err_q        <= err_d;
      run_q        <= run_d;
      hi_len_q     <= hi_len_d;
      lo_len_q     <= lo_len_d;
      period_cnt_q <= period_cnt_d;
      good_cnt_q   <= good_cnt_d;
    end
  end

  assign locked     = (state_q == StLocked);
  assign err        = err_q;
  assign hi_len     = hi_len_q;
  assign lo_len     = lo_len_q;
  assign period_cnt = period_cnt_q;

endmodule

// File: tb/tb_div_clk_checker.sv
// Scoreboard bench for div_clk_checker: expected outputs are queued against a step index
// when stimulus is planned, and compared when the bench reaches that step.
`timescale 1ns/1ps
module tb_div_clk_checker;

  logic       clk_in = 1'b0;
  logic       rst    = 1'b1;
  logic       div_clk = 1'b0;
  logic       clear   = 1'b0;
  logic       locked, err;
  logic [7:0] hi_len, lo_len;
  logic [3:0] period_cnt;

  div_clk_checker #(
    .DIVIDOR   (5),
    .LOCK_COUNT(4),
    .CNT_W     (8),
    .PCNT_W    (4)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .div_clk   (div_clk),
    .clear     (clear),
    .locked    (locked),
    .err       (err),
    .hi_len    (hi_len),
    .lo_len    (lo_len),
    .period_cnt(period_cnt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int         at;
    logic       lk;
    logic       er;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [3:0] pc;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic expect_rel(input int rel, input logic lk, input logic er, input logic [7:0] hi,
                            input logic [7:0] lo, input logic [3:0] pc, input string tag);
    exp_t e;
    e.at = cyc + rel; e.lk = lk; e.er = er; e.hi = hi; e.lo = lo; e.pc = pc; e.tag = tag;
    sb.push_back(e);
  endtask

  // One clk_in cycle: drive on the falling edge, sample 1ns after the rising edge.
  task automatic step(input logic d, input logic clr);
    exp_t e;
    @(negedge clk_in);
    div_clk = d;
    clear   = clr;
    @(posedge clk_in);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      n_vec++;
      if ({locked, err, hi_len, lo_len, period_cnt} !== {e.lk, e.er, e.hi, e.lo, e.pc}) begin
        n_bad++;
        $display("FAIL %s @step %0d: got locked=%b err=%b hi=%0d lo=%0d pcnt=%0d, want locked=%b err=%b hi=%0d lo=%0d pcnt=%0d",
                 e.tag, cyc, locked, err, hi_len, lo_len, period_cnt,
                 e.lk, e.er, e.hi, e.lo, e.pc);
      end
    end
  endtask

  task automatic wave(input int hi, input int lo);
    repeat (hi) step(1'b1, 1'b0);
    repeat (lo) step(1'b0, 1'b0);
  endtask

  task automatic test_reset;
    #1;
    n_vec++;
    if ({locked, err, hi_len, lo_len, period_cnt} !== 21'd0) begin
      n_bad++;
      $display("FAIL reset_async: got %b want 0", {locked, err, hi_len, lo_len, period_cnt});
    end
    expect_rel(1, 0, 0, 0, 0, 0, "reset_clocked");
    step(1'b0, 1'b0);
    @(negedge clk_in);
    rst = 1'b0;
  endtask

  // Starts from UNLOCKED with div_clk low and all outputs zero; ends locked, pcnt=1.
  task automatic test_clean;
    expect_rel(1,  0, 0, 0, 0, 0, "clean_prime");
    expect_rel(6,  0, 0, 5, 0, 0, "clean_hi");
    expect_rel(11, 0, 0, 5, 5, 0, "clean_lo");
    expect_rel(20, 0, 0, 5, 5, 0, "clean_prelock");
    expect_rel(21, 1, 0, 5, 5, 0, "clean_lock");
    expect_rel(31, 1, 0, 5, 5, 1, "clean_pcnt");
    repeat (4) wave(5, 5);
  endtask

  task automatic test_clear_on_edge;
    expect_rel(4, 1, 0, 5, 5, 2, "clear_before");
    expect_rel(5, 0, 0, 0, 0, 0, "clear_edge");
    expect_rel(8, 0, 0, 0, 0, 0, "clear_hold");
    repeat (4) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
  endtask

  task automatic test_stretch;
    expect_rel(1,  1, 0, 5, 5, 2, "stretch_rise");
    expect_rel(6,  1, 0, 5, 5, 2, "stretch_long_hi");
    expect_rel(7,  0, 1, 6, 5, 2, "stretch_err");
    expect_rel(17, 0, 1, 5, 5, 2, "stretch_reacq");
    expect_rel(26, 0, 1, 5, 5, 2, "stretch_prelock");
    expect_rel(27, 1, 1, 5, 5, 2, "stretch_relock");
    expect_rel(32, 1, 1, 5, 5, 3, "stretch_pcnt");
    wave(6, 5);
    repeat (3) wave(5, 5);
  endtask

  task automatic test_stuck;
    expect_rel(1, 0, 0, 0, 0, 0, "stuck_clear");
    step(1'b0, 1'b1);
    test_clean();
    expect_rel(5,  1, 0, 5, 5, 1, "stuck_pre_timeout");
    expect_rel(6,  0, 1, 5, 5, 1, "stuck_timeout");
    expect_rel(20, 0, 1, 5, 5, 1, "stuck_hold");
    expect_rel(21, 0, 1, 5, 5, 1, "stuck_prime_only");
    expect_rel(26, 0, 1, 5, 5, 1, "stuck_first_check");
    expect_rel(40, 0, 1, 5, 5, 1, "stuck_prelock");
    expect_rel(41, 1, 1, 5, 5, 1, "stuck_relock");
    expect_rel(51, 1, 1, 5, 5, 2, "stuck_pcnt");
    repeat (20) step(1'b0, 1'b0);
    repeat (4) wave(5, 5);
  endtask

  task automatic test_async_reset;
    expect_rel(7, 0, 1, 6, 5, 3, "areset_acquire");
    wave(6, 2);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({locked, err, hi_len, lo_len, period_cnt} !== 21'd0) begin
      n_bad++;
      $display("FAIL areset_immediate: got %b want 0", {locked, err, hi_len, lo_len, period_cnt});
    end
    #0.5;
    rst = 1'b0;
    test_clean();
  endtask

  task automatic test_saturate;
    expect_rel(1,   1, 0, 5, 5, 2,  "sat_first");
    expect_rel(121, 1, 0, 5, 5, 14, "sat_14");
    expect_rel(131, 1, 0, 5, 5, 15, "sat_15");
    expect_rel(141, 1, 0, 5, 5, 15, "sat_hold");
    expect_rel(200, 1, 0, 5, 5, 15, "sat_end");
    repeat (20) wave(5, 5);
  endtask

  initial begin
    test_reset();
    test_clean();
    test_clear_on_edge();
    test_clean();
    test_stretch();
    test_stuck();
    test_async_reset();
    test_saturate();
    if (sb.size() != 0) begin
      n_bad += sb.size();
      $display("FAIL scoreboard_drain: %0d expectations never reached, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
